// File: rtl/host_link_bridge_if.sv
// Handshake bundle between host_link_bridge and its surroundings: host byte link,
// control-unit instruction port, readback push port and status flags.
interface host_link_bridge_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        instr_ready;
   logic        instr_ack;
   logic [31:0] instr_out;
   logic        readback_ready;
   logic        readback_write;
   logic [31:0] readback_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_timeout;
   logic        rb_overflow;

   // The bridge itself
   modport slave (
      input  rx_valid, rx_data, instr_ack, readback_write, readback_data, tx_ready,
      output rx_ready, instr_ready, instr_out, readback_ready, tx_valid, tx_data,
             rx_timeout, rb_overflow
   );

   // Host link, control unit and readback source seen as one driver
   modport master (
      output rx_valid, rx_data, instr_ack, readback_write, readback_data, tx_ready,
      input  rx_ready, instr_ready, instr_out, readback_ready, tx_valid, tx_data,
             rx_timeout, rb_overflow
   );
endinterface

// File: rtl/host_link_bridge.sv
// Host byte-stream bridge: packs 4 host bytes (MSB first) into an instruction word
// for the control unit, and serialises buffered 32-bit readback words back to the host.
module host_link_bridge #(
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int RB_FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   host_link_bridge_if.slave link
);
   localparam int PW = $clog2(RB_FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {RX_ASSEMBLE, RX_HOLD} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

   // ------------------------------------------------------------------ RX path
   rx_state_t   rx_state_reg;
   logic [1:0]  byte_cnt_reg;
   logic [TW-1:0] idle_cnt_reg;
   logic        instr_ready_reg;
   logic        rx_timeout_reg;
   logic [7:0]  instr_byte_reg [4];
   logic        rx_accept;
   logic        timeout_hit;

   assign rx_accept          = link.rx_valid && !instr_ready_reg;
   assign link.rx_ready      = !instr_ready_reg;
   assign link.instr_ready   = instr_ready_reg;
   assign link.rx_timeout    = rx_timeout_reg;

   generate
      if (TIMEOUT_CYCLES != 0) begin : g_timeout
         // A byte arriving on the expiry clk takes priority over the discard
         assign timeout_hit = (rx_state_reg == RX_ASSEMBLE) && (byte_cnt_reg != 2'd0) &&
                              !rx_accept && (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_reg    <= RX_ASSEMBLE;
         byte_cnt_reg    <= 2'd0;
         idle_cnt_reg    <= '0;
         instr_ready_reg <= 1'b0;
         rx_timeout_reg  <= 1'b0;
      end else begin
         rx_timeout_reg <= 1'b0;
         case (rx_state_reg)
            RX_ASSEMBLE: begin
               if (rx_accept) begin
                  idle_cnt_reg <= '0;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     instr_ready_reg <= 1'b1;
                     rx_state_reg    <= RX_HOLD;
                  end
               end else if (timeout_hit) begin
                  idle_cnt_reg   <= '0;
                  byte_cnt_reg   <= 2'd0;
                  rx_timeout_reg <= 1'b1;
               end else if (byte_cnt_reg != 2'd0) begin
                  idle_cnt_reg <= idle_cnt_reg + TW'(1);
               end else begin
                  idle_cnt_reg <= '0;
               end
            end
            RX_HOLD: begin
               if (link.instr_ack) begin
                  instr_ready_reg <= 1'b0;
                  byte_cnt_reg    <= 2'd0;
                  rx_state_reg    <= RX_ASSEMBLE;
               end
            end
            default: rx_state_reg <= RX_ASSEMBLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               instr_byte_reg[gi] <= 8'h00;
            else if (rx_accept && rx_state_reg == RX_ASSEMBLE && byte_cnt_reg == 2'(gi))
               instr_byte_reg[gi] <= link.rx_data;
         end
         assign link.instr_out[31-8*gi -: 8] = instr_byte_reg[gi];
      end
   endgenerate

   // ------------------------------------------------------------ readback FIFO
   logic [31:0]   fifo_mem [RB_FIFO_DEPTH];
   logic [31:0]   rd_data_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          rb_overflow_reg;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   tx_state_t     tx_state_reg;

   assign fifo_full           = (count_reg == CW'(RB_FIFO_DEPTH));
   assign fifo_empty          = (count_reg == '0);
   assign push                = link.readback_write && !fifo_full;
   assign pop                 = (tx_state_reg == TX_IDLE) && !fifo_empty;
   assign link.readback_ready = !fifo_full;
   assign link.rb_overflow    = rb_overflow_reg;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= link.readback_data;
   end

   always_ff @(posedge clk) begin
      if (pop)
         rd_data_reg <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         rb_overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (push && !pop)
            count_reg <= count_reg + CW'(1);
         else if (pop && !push)
            count_reg <= count_reg - CW'(1);
         // Full-time writes are lost even if the same clk frees a slot
         if (link.readback_write && fifo_full)
            rb_overflow_reg <= 1'b1;
      end
   end

   // ------------------------------------------------------------------ TX path
   logic [23:0] tx_shift_reg;
   logic [1:0]  tx_idx_reg;
   logic        tx_valid_reg;
   logic [7:0]  tx_data_reg;

   assign link.tx_valid = tx_valid_reg;
   assign link.tx_data  = tx_data_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_reg <= TX_IDLE;
         tx_shift_reg <= 24'h0;
         tx_idx_reg   <= 2'd0;
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
      end else begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (!fifo_empty)
                  tx_state_reg <= TX_LOAD;
            end
            TX_LOAD: begin
               tx_valid_reg <= 1'b1;
               tx_data_reg  <= rd_data_reg[31:24];
               tx_shift_reg <= rd_data_reg[23:0];
               tx_idx_reg   <= 2'd0;
               tx_state_reg <= TX_SEND;
            end
            TX_SEND: begin
               if (link.tx_ready) begin
                  if (tx_idx_reg == 2'd3) begin
                     tx_valid_reg <= 1'b0;
                     tx_state_reg <= TX_IDLE;
                  end else begin
                     tx_data_reg  <= tx_shift_reg[23:16];
                     tx_shift_reg <= {tx_shift_reg[15:0], 8'h00};
                     tx_idx_reg   <= tx_idx_reg + 2'd1;
                  end
               end
            end
            default: tx_state_reg <= TX_IDLE;
         endcase
      end
   end
endmodule
